sap1_controller: RTL and testbench
==================================

# sap1_controller

Control sequencer for the SAP-1 datapath. Steps a six-state T-cycle ring (fetch T1–T3, execute T4–T6), decodes the opcode nibble held in the instruction register, and drives every bus-enable and load strobe: program counter, MAR, RAM, IR, accumulator A, register B, output register, and the ALU's `OpSelect`/`ALUOut` pair. Sits beside the datapath and is the only source of control-word bits.

## Interface
- Parameters: none; data width fixed at 8 bits, opcode = `instr[7:4]`.
- One clock; reset is asynchronous and active-high.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: 1 = sequencer advances; 0 = freeze current state, all strobes low.
- `instr` in 8: instruction register contents; only `[7:4]` decoded.
- `PcInc` out 1: program counter increment (Cp).
- `PcOut` out 1: PC drives bus (Ep).
- `MarLoad` out 1: MAR loads from bus (Lm).
- `RamOut` out 1: RAM drives bus (CE).
- `IrLoad` out 1: IR loads from bus (Li).
- `IrOut` out 1: IR operand nibble drives bus (Ei).
- `ALoad` out 1: accumulator loads (La).
- `AOut` out 1: accumulator drives bus (Ea).
- `BLoad` out 1: register B loads (Lb).
- `OutLoad` out 1: output register loads (Lo).
- `OpSelect` out 2: ALU op, 00 add, 01 sub, 10 or, 11 and.
- `ALUOut` out 1: ALU result drives bus (Eu).
- `tstate` out 6: one-hot current T-state, bit0 = T1.
- `halted` out 1: HLT executed; sequencer stopped.

## Operation
- States: T1..T6 ring plus HALT. T6 → T1. Advance only on clock edge with `run`=1, `rst`=0, not halted.
- Outputs are Moore decode of state and `instr[7:4]`; any strobe not listed for a state is 0; `OpSelect` = 00 unless listed.
- Fetch (all opcodes): T1: `PcOut`, `MarLoad`. T2: `PcInc`. T3: `RamOut`, `IrLoad`.
- Opcodes: 0000 LDA, 0001 ADD, 0010 SUB, 0011 OR, 0100 AND, 1110 OUT, 1111 HLT; all others NOP.
- LDA: T4 `IrOut`,`MarLoad`; T5 `RamOut`,`ALoad`; T6 idle.
- ADD/SUB/OR/AND: T4 `IrOut`,`MarLoad`; T5 `RamOut`,`BLoad`; T6 `ALUOut`,`ALoad`, `OpSelect` = 00/01/10/11 respectively.
- OUT: T4 `AOut`,`OutLoad`; T5, T6 idle.
- NOP: T4–T6 idle (fixed 6-cycle instruction length).
- HLT: T4 outputs all strobes 0; next advancing edge enters HALT instead of T5. HALT: all strobes 0, `tstate` = 000000, `halted`=1; exits only via `rst`.
- `run`=0: state held, all strobes and `OpSelect` forced 0, `tstate` still reports held state; `halted` unaffected. Resuming re-asserts the held state's strobes for exactly one cycle (no double `PcInc`, because T2 lasts one advancing edge).
- At most one bus driver (`PcOut`,`RamOut`,`IrOut`,`AOut`,`ALUOut`) high in any cycle; implementation must guarantee by construction.

## Timing
- Reset (asynchronous assert, synchronous-to-edge release): state = T1, `halted`=0, `tstate`=000001; while `rst`=1 all strobes and `OpSelect` forced 0. First edge after release with `run`=1 moves T1→T2, so T1 strobes are visible for the first full cycle after release.
- `rst` mid-instruction (any state, incl. HALT): immediately to T1, strobes 0; no partial completion.
- Strobes are combinational from registered state; datapath samples them on the next rising edge. One instruction = 6 advancing edges; HLT reaches HALT after 4.
- `instr` must be stable T4–T6 (IR loads only at end of T3); decode in T1–T3 is ignored.

## Test plan
- Reset with `run`=1, `instr`=0x00: `tstate` 000001→000010→000100 over 2 edges; T1 `PcOut`=`MarLoad`=1, T2 `PcInc`=1 only, T3 `RamOut`=`IrLoad`=1.
- `instr`=0x2A (SUB): T4 `IrOut`,`MarLoad`; T5 `RamOut`,`BLoad`; T6 `ALUOut`=`ALoad`=1, `OpSelect`=01; then back to T1.
- `instr`=0x3F, 0x4F, 0x1F: T6 `OpSelect` = 10, 11, 00 respectively; `instr`=0x7F: T4–T6 all strobes 0.
- `instr`=0xE0 (OUT): T4 `AOut`=`OutLoad`=1; `instr`=0xF0: after T4 edge `halted`=1, `tstate`=0, strobes 0 for 20 cycles; `rst` pulse returns to T1, `halted`=0.
- `run` dropped in T2 for 5 cycles: `tstate` stays 000010, `PcInc`=0 throughout; on `run`=1 `PcInc`=1 for exactly one cycle.
- Random `instr`/`run` for 10k cycles: assert at most one bus driver high per cycle, `tstate` one-hot or zero only when halted.

Source files
------------

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state T-cycle ring plus HALT, decoding instr[7:4]
// into the bus-enable and load strobes of the SAP-1 datapath.
module sap1_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instr,
  output logic       PcInc,
  output logic       PcOut,
  output logic       MarLoad,
  output logic       RamOut,
  output logic       IrLoad,
  output logic       IrOut,
  output logic       ALoad,
  output logic       AOut,
  output logic       BLoad,
  output logic       OutLoad,
  output logic [1:0] OpSelect,
  output logic       ALUOut,
  output logic [5:0] tstate,
  output logic       halted
);

  typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT} state_t;
  typedef enum logic [2:0] {BUS_NONE, BUS_PC, BUS_RAM, BUS_IR, BUS_A, BUS_ALU} bus_t;

  typedef struct packed {
    logic       pc_inc;
    logic       mar_load;
    logic       ir_load;
    logic       a_load;
    logic       b_load;
    logic       out_load;
    logic [1:0] op_sel;
  } ctl_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state;
  bus_t       bus;
  ctl_t       ctl;
  logic [3:0] op;
  logic       is_alu;
  logic       active;
  logic       instr_unused;

  assign op           = instr[7:4];
  assign instr_unused = ^instr[3:0];
  assign is_alu       = (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) || (op == OP_AND);
  assign active       = run & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= T1;
    else if (run) begin
      case (state)
        T1:      state <= T2;
        T2:      state <= T3;
        T3:      state <= T4;
        T4:      state <= (op == OP_HLT) ? HALT : T5;
        T5:      state <= T6;
        T6:      state <= T1;
        default: state <= HALT;
      endcase
    end
  end

  // A single bus-select value per state makes more than one bus driver impossible.
  always_comb begin
    bus = BUS_NONE;
    ctl = '0;
    case (state)
      T1: begin bus = BUS_PC;  ctl.mar_load = 1'b1; end
      T2: ctl.pc_inc = 1'b1;
      T3: begin bus = BUS_RAM; ctl.ir_load  = 1'b1; end
      T4: begin
        if (op == OP_LDA || is_alu) begin bus = BUS_IR; ctl.mar_load = 1'b1; end
        else if (op == OP_OUT)      begin bus = BUS_A;  ctl.out_load = 1'b1; end
      end
      T5: begin
        if (op == OP_LDA)  begin bus = BUS_RAM; ctl.a_load = 1'b1; end
        else if (is_alu)   begin bus = BUS_RAM; ctl.b_load = 1'b1; end
      end
      T6: begin
        if (is_alu) begin
          bus        = BUS_ALU;
          ctl.a_load = 1'b1;
          case (op)
            OP_SUB:  ctl.op_sel = 2'b01;
            OP_OR:   ctl.op_sel = 2'b10;
            OP_AND:  ctl.op_sel = 2'b11;
            default: ctl.op_sel = 2'b00;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign PcOut    = active & (bus == BUS_PC);
  assign RamOut   = active & (bus == BUS_RAM);
  assign IrOut    = active & (bus == BUS_IR);
  assign AOut     = active & (bus == BUS_A);
  assign ALUOut   = active & (bus == BUS_ALU);
  assign PcInc    = active & ctl.pc_inc;
  assign MarLoad  = active & ctl.mar_load;
  assign IrLoad   = active & ctl.ir_load;
  assign ALoad    = active & ctl.a_load;
  assign BLoad    = active & ctl.b_load;
  assign OutLoad  = active & ctl.out_load;
  assign OpSelect = active ? ctl.op_sel : 2'b00;
  assign halted   = (state == HALT);

  always_comb begin
    case (state)
      T1:      tstate = 6'b000001;
      T2:      tstate = 6'b000010;
      T3:      tstate = 6'b000100;
      T4:      tstate = 6'b001000;
      T5:      tstate = 6'b010000;
      T6:      tstate = 6'b100000;
      default: tstate = 6'b000000;
    endcase
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Scenario bench for sap1_controller: hand-written expected control words go
// through a scoreboard queue; a random phase checks bus exclusivity and tstate.
module tb_sap1_controller;

  logic       clk, rst, run;
  logic [7:0] instr;
  logic       PcInc, PcOut, MarLoad, RamOut, IrLoad, IrOut;
  logic       ALoad, AOut, BLoad, OutLoad, ALUOut, halted;
  logic [1:0] OpSelect;
  logic [5:0] tstate;

  sap1_controller dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .PcInc(PcInc), .PcOut(PcOut), .MarLoad(MarLoad), .RamOut(RamOut),
    .IrLoad(IrLoad), .IrOut(IrOut), .ALoad(ALoad), .AOut(AOut),
    .BLoad(BLoad), .OutLoad(OutLoad), .OpSelect(OpSelect), .ALUOut(ALUOut),
    .tstate(tstate), .halted(halted)
  );

  localparam logic [19:0] HL = 20'h80000;
  localparam logic [19:0] PI = 20'h00400;
  localparam logic [19:0] PO = 20'h00200;
  localparam logic [19:0] ML = 20'h00100;
  localparam logic [19:0] RO = 20'h00080;
  localparam logic [19:0] IL = 20'h00040;
  localparam logic [19:0] IO = 20'h00020;
  localparam logic [19:0] AL = 20'h00010;
  localparam logic [19:0] AO = 20'h00008;
  localparam logic [19:0] BL = 20'h00004;
  localparam logic [19:0] OL = 20'h00002;
  localparam logic [19:0] UO = 20'h00001;

  typedef struct {
    logic        r;
    logic        rn;
    logic [7:0]  ins;
    logic [19:0] exp;
  } step_t;

  step_t       plan[$];
  logic [19:0] sbq[$];
  int          nchk = 0;
  int          npass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, checks %0d", nchk);
    $fatal(1);
  end

  function automatic logic [19:0] ts(input int n);
    return (n == 0) ? 20'h0 : (20'(1) << (12 + n));
  endfunction

  function automatic logic [19:0] ops(input int k);
    return 20'(k) << 11;
  endfunction

  function automatic logic [19:0] obs();
    return {halted, tstate, OpSelect, PcInc, PcOut, MarLoad, RamOut, IrLoad,
            IrOut, ALoad, AOut, BLoad, OutLoad, ALUOut};
  endfunction

  task automatic add(input logic r, input logic rn, input logic [7:0] ins, input logic [19:0] e);
    step_t s;
    s.r = r; s.rn = rn; s.ins = ins; s.exp = e;
    plan.push_back(s);
  endtask

  task automatic add_fetch(input logic [7:0] ins);
    add(0, 1, ins, ts(1) | PO | ML);
    add(0, 1, ins, ts(2) | PI);
    add(0, 1, ins, ts(3) | RO | IL);
  endtask

  task automatic add_nop();
    add_fetch(8'h7F);
    for (int t = 4; t <= 6; t++) add(0, 1, 8'h7F, ts(t));
  endtask

  task automatic test_reset();
    logic [19:0] got, e;
    step_t s;
    int k = 0;
    add(1, 1, 8'h00, ts(1));
    add_fetch(8'h00);
    add(0, 1, 8'h00, ts(4) | IO | ML);
    add(0, 1, 8'h00, ts(5) | RO | AL);
    add(0, 1, 8'h00, ts(6));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      rst = s.r; run = s.rn; instr = s.ins; sbq.push_back(s.exp);
      @(negedge clk);
      got = obs(); e = sbq.pop_front(); nchk++;
      if (got !== e) $display("FAIL reset_lda step %0d: got %h want %h", k, got, e);
      else npass++;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_alu();
    logic [7:0]  ins[4] = '{8'h2A, 8'h3F, 8'h4F, 8'h1F};
    int          sel[4] = '{1, 2, 3, 0};
    logic [19:0] got, e;
    step_t s;
    int k = 0;
    for (int i = 0; i < 4; i++) begin
      add_fetch(ins[i]);
      add(0, 1, ins[i], ts(4) | IO | ML);
      add(0, 1, ins[i], ts(5) | RO | BL);
      add(0, 1, ins[i], ts(6) | UO | AL | ops(sel[i]));
    end
    add_nop();
    add_fetch(8'hE0);
    add(0, 1, 8'hE0, ts(4) | AO | OL);
    add(0, 1, 8'hE0, ts(5));
    add(0, 1, 8'hE0, ts(6));
    add(0, 1, 8'h00, ts(1) | PO | ML);
    add(0, 1, 8'h00, ts(2) | PI);
    add(0, 1, 8'h00, ts(3) | RO | IL);
    add(0, 1, 8'h00, ts(4) | IO | ML);
    add(0, 1, 8'h00, ts(5) | RO | AL);
    add(0, 1, 8'h00, ts(6));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      rst = s.r; run = s.rn; instr = s.ins; sbq.push_back(s.exp);
      @(negedge clk);
      got = obs(); e = sbq.pop_front(); nchk++;
      if (got !== e) $display("FAIL alu_out_nop step %0d: got %h want %h", k, got, e);
      else npass++;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_run_pause();
    logic [19:0] got, e;
    step_t s;
    int k = 0;
    add(0, 1, 8'h7F, ts(1) | PO | ML);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h7F, ts(2));
    add(0, 1, 8'h7F, ts(2) | PI);
    add(0, 1, 8'h7F, ts(3) | RO | IL);
    add(0, 0, 8'h7F, ts(4));
    for (int t = 4; t <= 6; t++) add(0, 1, 8'h7F, ts(t));
    while (plan.size() > 0) begin
      s = plan.pop_front();
      rst = s.r; run = s.rn; instr = s.ins; sbq.push_back(s.exp);
      @(negedge clk);
      got = obs(); e = sbq.pop_front(); nchk++;
      if (got !== e) $display("FAIL run_pause step %0d: got %h want %h", k, got, e);
      else npass++;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_rst_mid();
    logic [19:0] got, e;
    step_t s;
    int k = 0;
    add_fetch(8'h15);
    add(0, 1, 8'h15, ts(4) | IO | ML);
    add(1, 1, 8'h15, ts(1));
    add_nop();
    while (plan.size() > 0) begin
      s = plan.pop_front();
      rst = s.r; run = s.rn; instr = s.ins; sbq.push_back(s.exp);
      @(negedge clk);
      got = obs(); e = sbq.pop_front(); nchk++;
      if (got !== e) $display("FAIL rst_mid step %0d: got %h want %h", k, got, e);
      else npass++;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_halt();
    logic [19:0] got, e;
    step_t s;
    int k = 0;
    add_fetch(8'hF0);
    add(0, 1, 8'hF0, ts(4));
    for (int i = 0; i < 20; i++) add(0, 1, 8'hF0, HL);
    add(0, 0, 8'hF0, HL);
    add(1, 1, 8'hF0, ts(1));
    add_nop();
    while (plan.size() > 0) begin
      s = plan.pop_front();
      rst = s.r; run = s.rn; instr = s.ins; sbq.push_back(s.exp);
      @(negedge clk);
      got = obs(); e = sbq.pop_front(); nchk++;
      if (got !== e) $display("FAIL halt step %0d: got %h want %h", k, got, e);
      else npass++;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_random();
    int nbus, nbad = 0;
    logic ok;
    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      run   = ($urandom_range(0, 3) != 0);
      instr = 8'($urandom_range(0, 255));
      @(negedge clk);
      nbus = int'(PcOut) + int'(RamOut) + int'(IrOut) + int'(AOut) + int'(ALUOut);
      ok = (nbus <= 1) && (halted ? (tstate == 6'b0) : $onehot(tstate));
      if ((rst || !run) && (obs() & 20'h01FFF) != 20'h0) ok = 1'b0;
      nchk++;
      if (!ok) begin
        nbad++;
        if (nbad <= 10)
          $display("FAIL random cycle %0d: bus drivers %0d tstate %b halted %b word %h",
                   i, nbus, tstate, halted, obs());
      end else npass++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr = 8'h00;
    test_reset();
    test_alu();
    test_run_pause();
    test_rst_mid();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
